// File: rtl/pads_cfg_pkg.sv
// Shared constants, state encoding and chain packing for the pad configuration sequencer.
package pads_cfg_pkg;

  localparam int NUM_PADS   = 44;
  localparam int CFG_BITS   = 2;
  localparam int CHAIN_LEN  = NUM_PADS * CFG_BITS;
  localparam int IDX_W      = 6;
  localparam int BIT_CNT_W  = $clog2(CHAIN_LEN + 1);

  // Per-pad field positions inside a CFG_BITS-wide configuration word.
  localparam int CFG_IO_BIT = 0;
  localparam int CFG_EN_BIT = 1;

  localparam logic [NUM_PADS-1:0] RST_IO = 44'h38FFFC00042;
  localparam logic [NUM_PADS-1:0] RST_EN = {NUM_PADS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Chain is shifted MSB first, so pad NUM_PADS-1 en lands in the top bit.
  function automatic logic [CHAIN_LEN-1:0] pack_chain(input logic [NUM_PADS-1:0] io,
                                                      input logic [NUM_PADS-1:0] en);
    logic [CHAIN_LEN-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      c[i*CFG_BITS + CFG_IO_BIT] = io[i];
      c[i*CFG_BITS + CFG_EN_BIT] = en[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/pads_cfg_sclk_gen.sv
// Divided serial clock phase generator: a CLK_DIV counter toggling a low/high phase.
module pads_cfg_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic en_i,
  output logic phase_hi_o,
  output logic phase_tick_o,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Disabled means parked at the start of a low phase, ready for the next bit.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_hi_o   = phase_q;
  assign phase_tick_o = en_i && wrap;
  assign bit_tick_o   = en_i && wrap && phase_q;

endmodule

// File: rtl/pads_cfg_seq.sv
// Pad configuration shadow and serial chain sequencer (shift, then load strobe).
// Optional PADS_CFG_AUTOLOAD_EN: apply the reset shadow once automatically after reset.
module pads_cfg_seq
  import pads_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [CFG_BITS-1:0] wr_cfg,
  output logic                wr_err,
  input  logic                apply_req,
  output logic                busy,
  output logic                done,
  output logic                serial_clk,
  output logic                serial_data,
  output logic                serial_load,
  output logic [NUM_PADS-1:0] cnfg_io,
  output logic [NUM_PADS-1:0] cnfg_en,
  output logic [1:0]          dbg_state
);

`ifdef PADS_CFG_AUTOLOAD_EN
  localparam logic PENDING_RST = 1'b1;
`else
  localparam logic PENDING_RST = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [NUM_PADS-1:0]    io_q, io_d;
  logic [NUM_PADS-1:0]    en_q, en_d;
  logic [CHAIN_LEN-1:0]   chain_q, chain_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   pending_q, pending_d;
  logic                   wr_err_q, wr_err_d;

  logic                   wr_ok;
  logic                   start;
  logic                   last_bit;
  logic                   sclk_en;
  logic                   phase_hi;
  logic                   phase_tick;
  logic                   bit_tick;

  pads_cfg_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk          (clk),
    .resetb       (resetb),
    .en_i         (sclk_en),
    .phase_hi_o   (phase_hi),
    .phase_tick_o (phase_tick),
    .bit_tick_o   (bit_tick)
  );

  assign wr_ok    = wr_en && (wr_idx < IDX_W'(NUM_PADS));
  assign start    = (state_q == ST_IDLE) && (apply_req || pending_q);
  assign last_bit = (bit_cnt_q == BIT_CNT_W'(CHAIN_LEN - 1));

  // Shadow writes are accepted in every state; the chain register is a separate copy.
  always_comb begin
    io_d     = io_q;
    en_d     = en_q;
    wr_err_d = wr_en && !wr_ok;
    if (wr_ok) begin
      io_d[wr_idx] = wr_cfg[CFG_IO_BIT];
      en_d[wr_idx] = wr_cfg[CFG_EN_BIT];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_tick && last_bit) state_d = ST_LOAD;
      ST_LOAD:  if (phase_tick) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    serial_clk  = 1'b0;
    serial_data = 1'b0;
    serial_load = 1'b0;
    sclk_en     = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        busy        = 1'b1;
        sclk_en     = 1'b1;
        serial_clk  = phase_hi;
        serial_data = chain_q[CHAIN_LEN-1];
      end
      ST_LOAD: begin
        busy        = 1'b1;
        sclk_en     = 1'b1;
        serial_load = 1'b1;
      end
      ST_DONE: begin
        done        = 1'b1;
      end
      default: begin
        busy        = 1'b0;
      end
    endcase
  end

  // Snapshot takes the next-state shadow so a same-cycle write is included.
  always_comb begin
    chain_d   = chain_q;
    bit_cnt_d = bit_cnt_q;
    pending_d = pending_q;
    if (start) begin
      chain_d   = pack_chain(io_d, en_d);
      bit_cnt_d = '0;
      pending_d = 1'b0;
    end else begin
      if (apply_req && (state_q != ST_IDLE)) begin
        pending_d = 1'b1;
      end
      if ((state_q == ST_SHIFT) && bit_tick) begin
        chain_d   = {chain_q[CHAIN_LEN-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      io_q      <= RST_IO;
      en_q      <= RST_EN;
      chain_q   <= '0;
      bit_cnt_q <= '0;
      pending_q <= PENDING_RST;
      wr_err_q  <= 1'b0;
    end else begin
      io_q      <= io_d;
      en_q      <= en_d;
      chain_q   <= chain_d;
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign wr_err    = wr_err_q;
  assign cnfg_io   = io_q;
  assign cnfg_en   = en_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pads_cfg_seq.sv
// Scoreboard bench for pads_cfg_seq: serial chain capture checked against a pad-list model.
module tb_pads_cfg_seq;

  localparam int NP = 44;
  localparam int CL = 88;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          wr_en = 1'b0;
  logic [5:0]    wr_idx = '0;
  logic [1:0]    wr_cfg = '0;
  logic          apply_req = 1'b0;
  logic          wr_err, busy, done, serial_clk, serial_data, serial_load;
  logic [NP-1:0] cnfg_io, cnfg_en;
  logic [1:0]    dbg_state;

  pads_cfg_seq dut (
    .clk         (clk),
    .resetb      (resetb),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_cfg      (wr_cfg),
    .wr_err      (wr_err),
    .apply_req   (apply_req),
    .busy        (busy),
    .done        (done),
    .serial_clk  (serial_clk),
    .serial_data (serial_data),
    .serial_load (serial_load),
    .cnfg_io     (cnfg_io),
    .cnfg_en     (cnfg_en),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic m_io [NP];
  logic m_en [NP];
  logic [CL-1:0] exp_q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    logic [NP-1:0] rio;
    rio = 44'h38FFFC00042;
    for (int i = 0; i < NP; i++) begin
      m_io[i] = rio[i];
      m_en[i] = 1'b1;
    end
  endfunction

  function automatic logic [NP-1:0] model_io();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = m_io[i];
    return v;
  endfunction

  function automatic logic [NP-1:0] model_en();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = m_en[i];
    return v;
  endfunction

  // Transmission order: highest pad first, en before io within a pad.
  function automatic logic [CL-1:0] model_chain();
    logic b[$];
    logic [CL-1:0] c;
    c = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      b.push_back(m_en[p]);
      b.push_back(m_io[p]);
    end
    foreach (b[k]) c = {c[CL-2:0], b[k]};
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic monitor();
    logic [CL-1:0] cap;
    logic [CL-1:0] e;
    int nbits;
    logic prev_sclk;
    cap = '0;
    nbits = 0;
    prev_sclk = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        exp_q.delete();
        nbits = 0;
        prev_sclk = 1'b0;
      end else begin
        if (serial_clk && !prev_sclk) begin
          cap = {cap[CL-2:0], serial_data};
          nbits++;
        end
        prev_sclk = serial_clk;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_done: got done with no sequence expected");
          end else begin
            e = exp_q.pop_front();
            check("sb_nbits", nbits, CL);
            check("sb_chain", cap, e);
          end
          nbits = 0;
        end
      end
    end
  endtask

  task automatic do_write(input int idx, input logic [1:0] cfg);
    wr_en = 1'b1;
    wr_idx = 6'(idx);
    wr_cfg = cfg;
    tick();
    wr_en = 1'b0;
    check("wr_err", wr_err, idx >= NP);
    if (idx < NP) begin
      m_io[idx] = cfg[0];
      m_en[idx] = cfg[1];
    end
    check("shadow_io", cnfg_io, model_io());
    check("shadow_en", cnfg_en, model_en());
  endtask

  task automatic start_apply(input logic wr, input int idx, input logic [1:0] cfg, output int t0);
    if (wr) begin
      wr_en = 1'b1;
      wr_idx = 6'(idx);
      wr_cfg = cfg;
      m_io[idx] = cfg[0];
      m_en[idx] = cfg[1];
    end
    apply_req = 1'b1;
    exp_q.push_back(model_chain());
    tick();
    apply_req = 1'b0;
    wr_en = 1'b0;
    t0 = cyc;
    check("busy_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int t0, input logic req_in_done);
    int ld_cnt;
    int ld_last;
    logic busy_ok;
    logic seen;
    ld_cnt = 0;
    ld_last = -1;
    busy_ok = 1'b1;
    seen = 1'b0;
    while (!seen && (cyc - t0) < 2000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (serial_load) begin
          ld_cnt++;
          ld_last = cyc - t0;
        end
        tick();
      end
    end
    check("done_seen", seen, 1'b1);
    check("done_latency", cyc - t0, 708);
    check("load_cycles", ld_cnt, 4);
    check("load_end", ld_last, 707);
    check("busy_held", busy_ok, 1'b1);
    check("busy_in_done", busy, 1'b0);
    if (req_in_done) apply_req = 1'b1;
    tick();
    apply_req = 1'b0;
    check("done_pulse", done, 1'b0);
  endtask

  task automatic after_reset();
    int t0;
    logic quiet_ok;
    check("rst_io", cnfg_io, model_io());
    check("rst_en", cnfg_en, model_en());
    check("rst_pins", {busy, done, wr_err, serial_clk, serial_data, serial_load}, 6'b0);
`ifdef PADS_CFG_AUTOLOAD_EN
    exp_q.push_back(model_chain());
    tick();
    t0 = cyc;
    check("autoload_busy", busy, 1'b1);
    wait_done(t0, 1'b0);
    quiet_ok = 1'b1;
`else
    quiet_ok = 1'b1;
    repeat (20) begin
      tick();
      if ({busy, done, wr_err, serial_clk, serial_data, serial_load} != 6'b0) quiet_ok = 1'b0;
    end
    t0 = cyc;
`endif
    check("idle_quiet", quiet_ok, 1'b1);
  endtask

  initial begin
    int t0;
    int t1;
    int d0;
    logic quiet_ok;
    model_reset();
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    after_reset();

    // Basic apply after a single write.
    do_write(5, 2'b01);
    start_apply(1'b0, 0, 2'b00, t0);
    wait_done(t0, 1'b0);

    // Out-of-range write is dropped.
    do_write(50, 2'b10);
    tick();
    check("wr_err_pulse", wr_err, 1'b0);

    // Writes and repeated requests during SHIFT coalesce into one follow-up.
    start_apply(1'b0, 0, 2'b00, t0);
    repeat (40) tick();
    do_write(0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      apply_req = 1'b1;
      tick();
      apply_req = 1'b0;
      repeat (15) tick();
    end
    exp_q.push_back(model_chain());
    wait_done(t0, 1'b0);
    check("pend_gap", busy, 1'b0);
    tick();
    check("pend_start", busy, 1'b1);
    t1 = cyc;
    wait_done(t1, 1'b0);
    quiet_ok = 1'b1;
    repeat (30) begin
      tick();
      if (busy || done) quiet_ok = 1'b0;
    end
    check("no_extra_seq", quiet_ok, 1'b1);

    // Write-through with same-cycle apply; request in DONE becomes pending.
    start_apply(1'b1, 7, 2'b11, t0);
    exp_q.push_back(model_chain());
    wait_done(t0, 1'b1);
    check("done_req_gap", busy, 1'b0);
    tick();
    check("done_req_start", busy, 1'b1);
    t1 = cyc;
    wait_done(t1, 1'b0);

    // Random writes, then an apply with random writes while it shifts.
    repeat (10) do_write($urandom_range(0, 63), 2'($urandom_range(0, 3)));
    start_apply(1'b0, 0, 2'b00, t0);
    repeat (20) begin
      do_write($urandom_range(0, NP - 1), 2'($urandom_range(0, 3)));
      repeat (10) tick();
    end
    wait_done(t0, 1'b0);

    // Reset in the middle of a sequence.
    do_write(10, 2'b01);
    start_apply(1'b0, 0, 2'b00, t0);
    while ((cyc - t0) < 299) tick();
    d0 = done_cnt;
    @(posedge clk);
    #3;
    resetb = 1'b0;
    #1;
    model_reset();
    check("rst_async_io", cnfg_io, model_io());
    check("rst_async_en", cnfg_en, model_en());
    check("rst_async_pins", {busy, done, wr_err, serial_clk, serial_data, serial_load}, 6'b0);
    @(negedge clk);
    repeat (3) tick();
    resetb = 1'b1;
    check("no_done_on_reset", done_cnt, d0);
    after_reset();

    do_write(3, 2'b11);
    start_apply(1'b0, 0, 2'b00, t0);
    wait_done(t0, 1'b0);

    repeat (5) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
